// File: rtl/ps2_key_rx_if.sv
//------------------------------------------------------------------------------
// Module   : ps2_key_rx_if
// Brief    : Key-event stream between the PS/2 receiver and its consumer.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface ps2_key_rx_if;
  logic       ev_valid;
  logic       ev_ready;
  logic [7:0] ev_code;
  logic       ev_break;
  logic       ev_ext;

  modport master (output ev_valid, ev_code, ev_break, ev_ext, input  ev_ready);
  modport slave  (input  ev_valid, ev_code, ev_break, ev_ext, output ev_ready);
endinterface

`default_nettype wire

// File: rtl/ps2_key_rx.sv
//------------------------------------------------------------------------------
// Module   : ps2_key_rx
// Brief    : PS/2 keyboard receiver with frame checking, event FIFO and
//            held-key bitmap. Define PS2_EXT_EN to decode E0-prefixed keys.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module ps2_key_rx #(
  parameter int FILT_LEN    = 4,
  parameter int TIMEOUT_CYC = 100000,
  parameter int FIFO_DEPTH  = 8
) (
  input  wire logic        clk,
  input  wire logic        rst_n,
  input  wire logic        ps2_clk,
  input  wire logic        ps2_data,
  ps2_key_rx_if.master     ev,
  output logic [3:0]       key_held,
  output logic [1:0]       dir,
  output logic             frame_err,
  output logic             ovf,
  input  wire logic        ovf_clr
);

  localparam int c_FCW = $clog2(FILT_LEN + 1);
  localparam int c_TCW = $clog2(TIMEOUT_CYC + 1);
  localparam int c_CW  = $clog2(FIFO_DEPTH + 1);
  localparam logic [c_FCW-1:0] c_FILT_LAST = c_FCW'(FILT_LEN - 1);
  localparam logic [c_TCW-1:0] c_TMO_LAST  = c_TCW'(TIMEOUT_CYC - 1);
  localparam logic [c_CW-1:0]  c_FULL      = c_CW'(FIFO_DEPTH);

  localparam logic [1:0] c_S_IDLE = 2'd0;
  localparam logic [1:0] c_S_DATA = 2'd1;
  localparam logic [1:0] c_S_PAR  = 2'd2;
  localparam logic [1:0] c_S_STOP = 2'd3;

  // ---------------- synchronisers and clock filter ----------------
  logic [1:0]       r_clk_sync, r_dat_sync;
  logic             r_filt;
  logic [c_FCW-1:0] r_filt_cnt;
  logic             w_clk_s, w_dat_s, w_differ, w_flip, w_strobe;

  assign w_clk_s  = r_clk_sync[1];
  assign w_dat_s  = r_dat_sync[1];
  assign w_differ = (w_clk_s != r_filt);
  assign w_flip   = w_differ && (r_filt_cnt == c_FILT_LAST);
  assign w_strobe = w_flip && r_filt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_clk_sync <= 2'b11;
      r_dat_sync <= 2'b11;
      r_filt     <= 1'b1;
      r_filt_cnt <= '0;
    end else begin
      r_clk_sync <= {r_clk_sync[0], ps2_clk};
      r_dat_sync <= {r_dat_sync[0], ps2_data};
      if (!w_differ || w_flip) r_filt_cnt <= '0;
      else                     r_filt_cnt <= r_filt_cnt + 1'b1;
      if (w_flip) r_filt <= ~r_filt;
    end
  end

  // ---------------- frame FSM ----------------
  logic [1:0]       r_state, w_state_nxt;
  logic [7:0]       r_shift;
  logic [2:0]       r_bit_cnt;
  logic             r_par;
  logic [c_TCW-1:0] r_tmo_cnt;
  logic             w_timeout, w_byte_good, w_frame_bad;
  logic             r_byte_ok, r_frame_err;

  assign w_timeout = (r_state != c_S_IDLE) && !w_strobe && (r_tmo_cnt == c_TMO_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= c_S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (w_timeout) begin
      w_state_nxt = c_S_IDLE;
    end else if (w_strobe) begin
      case (r_state)
        c_S_IDLE: if (!w_dat_s) w_state_nxt = c_S_DATA;
        c_S_DATA: if (r_bit_cnt == 3'd7) w_state_nxt = c_S_PAR;
        c_S_PAR:  w_state_nxt = c_S_STOP;
        default:  w_state_nxt = c_S_IDLE;
      endcase
    end
  end

  // Odd parity over data+parity means the XOR of all nine bits is 1.
  always_comb begin
    w_byte_good = 1'b0;
    w_frame_bad = w_timeout;
    if ((r_state == c_S_STOP) && w_strobe) begin
      if (w_dat_s && (^{r_shift, r_par})) w_byte_good = 1'b1;
      else                                w_frame_bad = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shift     <= '0;
      r_bit_cnt   <= '0;
      r_par       <= 1'b0;
      r_tmo_cnt   <= '0;
      r_byte_ok   <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_byte_ok   <= w_byte_good;
      r_frame_err <= w_frame_bad;
      if ((r_state == c_S_IDLE) || w_strobe || w_timeout) r_tmo_cnt <= '0;
      else                                                r_tmo_cnt <= r_tmo_cnt + 1'b1;
      if (w_strobe) begin
        case (r_state)
          c_S_IDLE: r_bit_cnt <= '0;
          c_S_DATA: begin
            r_shift   <= {w_dat_s, r_shift[7:1]};
            r_bit_cnt <= r_bit_cnt + 1'b1;
          end
          c_S_PAR:  r_par <= w_dat_s;
          default:  ;
        endcase
      end
    end
  end

  // ---------------- prefix decoder ----------------
  logic w_is_f0, w_is_e0, w_is_kerr, w_push_req, w_ext;
  logic r_brk;
  logic [9:0] w_event;

  assign w_is_f0    = (r_shift == 8'hF0);
  assign w_is_e0    = (r_shift == 8'hE0);
  assign w_is_kerr  = (r_shift == 8'h00) || (r_shift == 8'hFF);
  assign w_push_req = r_byte_ok && !w_is_f0 && !w_is_e0 && !w_is_kerr;
  assign w_event    = {w_ext, r_brk, r_shift};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                       r_brk <= 1'b0;
    else if (r_byte_ok && !w_is_e0)   r_brk <= w_is_f0;
  end

`ifdef PS2_EXT_EN
  logic r_ext;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                       r_ext <= 1'b0;
    else if (r_byte_ok && !w_is_f0)   r_ext <= w_is_e0;
  end
  assign w_ext = r_ext;
`else
  assign w_ext = 1'b0;
`endif

  // ---------------- held-key bitmap and direction ----------------
  logic [3:0] w_key_sel, r_key_held;
  logic [1:0] r_dir;

  always_comb begin
    w_key_sel = 4'b0000;
    if (!w_ext) begin
      case (r_shift)
        8'h1D, 8'h43: w_key_sel = 4'b0001;
        8'h1C, 8'h3B: w_key_sel = 4'b0010;
        8'h23, 8'h4B: w_key_sel = 4'b0100;
        8'h1B, 8'h42: w_key_sel = 4'b1000;
        default:      w_key_sel = 4'b0000;
      endcase
    end
`ifdef PS2_EXT_EN
    else begin
      case (r_shift)
        8'h75:   w_key_sel = 4'b0001;
        8'h6B:   w_key_sel = 4'b0010;
        8'h74:   w_key_sel = 4'b0100;
        8'h72:   w_key_sel = 4'b1000;
        default: w_key_sel = 4'b0000;
      endcase
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_key_held <= '0;
      r_dir      <= 2'd0;
    end else begin
      if (w_push_req)
        r_key_held <= r_brk ? (r_key_held & ~w_key_sel) : (r_key_held | w_key_sel);
      if      (r_key_held[0]) r_dir <= 2'd1;
      else if (r_key_held[1]) r_dir <= 2'd2;
      else if (r_key_held[2]) r_dir <= 2'd3;
      else                    r_dir <= 2'd0;
    end
  end

  // ---------------- event FIFO ----------------
  // Shifting queue: slot 0 is always the head and unused slots hold zero.
  logic [c_CW-1:0] r_count;
  logic            w_pop, w_full, w_push, w_drop, r_ovf;

  assign w_pop  = (r_count != '0) && ev.ev_ready;
  assign w_full = (r_count == c_FULL);
  assign w_push = w_push_req && (!w_full || w_pop);
  assign w_drop = w_push_req && w_full && !w_pop;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
      r_ovf   <= 1'b0;
    end else begin
      r_count <= r_count + c_CW'(w_push) - c_CW'(w_pop);
      if (w_drop)       r_ovf <= 1'b1;
      else if (ovf_clr) r_ovf <= 1'b0;
    end
  end

  for (genvar i = 0; i < FIFO_DEPTH; i++) begin : g_slot
    logic [9:0] r_q;
    logic [9:0] w_above;
    if (i == FIFO_DEPTH - 1) begin : g_top
      assign w_above = '0;
    end else begin : g_mid
      assign w_above = g_slot[i+1].r_q;
    end
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_q <= '0;
      end else if (w_pop) begin
        if (w_push && (r_count == c_CW'(i + 1))) r_q <= w_event;
        else                                    r_q <= w_above;
      end else if (w_push && (r_count == c_CW'(i))) begin
        r_q <= w_event;
      end
    end
  end

  assign ev.ev_valid = (r_count != '0);
  assign ev.ev_ext   = g_slot[0].r_q[9];
  assign ev.ev_break = g_slot[0].r_q[8];
  assign ev.ev_code  = g_slot[0].r_q[7:0];
  assign key_held    = r_key_held;
  assign dir         = r_dir;
  assign frame_err   = r_frame_err;
  assign ovf         = r_ovf;

endmodule

`default_nettype wire

// File: tb/tb_ps2_key_rx.sv
//------------------------------------------------------------------------------
// Module   : tb_ps2_key_rx
// Brief    : Self-checking bench for ps2_key_rx using an event scoreboard.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_ps2_key_rx;
  localparam int FILT_LEN    = 4;
  localparam int TIMEOUT_CYC = 300;
  localparam int FIFO_DEPTH  = 8;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ps2_clk;
  logic       ps2_data;
  logic [3:0] key_held;
  logic [1:0] dir;
  logic       frame_err;
  logic       ovf;
  logic       ovf_clr;

  ps2_key_rx_if ev_if ();

  ps2_key_rx #(
    .FILT_LEN   (FILT_LEN),
    .TIMEOUT_CYC(TIMEOUT_CYC),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .ps2_clk  (ps2_clk),
    .ps2_data (ps2_data),
    .ev       (ev_if),
    .key_held (key_held),
    .dir      (dir),
    .frame_err(frame_err),
    .ovf      (ovf),
    .ovf_clr  (ovf_clr)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int err_cnt  = 0;
  int cyc      = 0;
  int t_held   = 0;
  int t_dir    = 0;
  logic [3:0] prev_held = '0;
  logic [1:0] prev_dir  = '0;
  logic [9:0] popped;

  // Scoreboard and reference decoder state
  logic [9:0] q[$];
  logic       m_brk, m_ext;
  logic [3:0] m_held;

  always @(negedge clk) begin
    cyc++;
    if (frame_err === 1'b1) err_cnt++;
    if (key_held !== prev_held) t_held = cyc;
    if (dir !== prev_dir) t_dir = cyc;
    prev_held = key_held;
    prev_dir  = dir;
  end

  function automatic logic [3:0] kmap(input logic e, input logic [7:0] c);
    logic [3:0] s;
    s = 4'b0000;
    if (!e) begin
      if (c == 8'h1D || c == 8'h43) s = 4'b0001;
      if (c == 8'h1C || c == 8'h3B) s = 4'b0010;
      if (c == 8'h23 || c == 8'h4B) s = 4'b0100;
      if (c == 8'h1B || c == 8'h42) s = 4'b1000;
    end else begin
      if (c == 8'h75) s = 4'b0001;
      if (c == 8'h6B) s = 4'b0010;
      if (c == 8'h74) s = 4'b0100;
      if (c == 8'h72) s = 4'b1000;
    end
    return s;
  endfunction

  function automatic logic [1:0] mdir(input logic [3:0] h);
    if (h[0]) return 2'd1;
    if (h[1]) return 2'd2;
    if (h[2]) return 2'd3;
    return 2'd0;
  endfunction

  function automatic logic [10:0] mk(input logic [7:0] b, input bit bad_par, input bit bad_stop);
    return {~bad_stop, (~^b) ^ bad_par, b, 1'b0};
  endfunction

  task automatic model_byte(input logic [7:0] b);
    logic [3:0] sel;
    if (b == 8'hF0) m_brk = 1'b1;
    else if (b == 8'hE0) begin
`ifdef PS2_EXT_EN
      m_ext = 1'b1;
`endif
    end else if (b == 8'h00 || b == 8'hFF) begin
      m_brk = 1'b0;
      m_ext = 1'b0;
    end else begin
      if (q.size() < FIFO_DEPTH) q.push_back({m_ext, m_brk, b});
      sel    = kmap(m_ext, b);
      m_held = m_brk ? (m_held & ~sel) : (m_held | sel);
      m_brk  = 1'b0;
      m_ext  = 1'b0;
    end
  endtask

  // Drives frame bits 0..nbits-1; optional short clock glitch and a one-cycle
  // pop timed to coincide with the FIFO write of the stop bit's byte.
  task automatic send_bits(input logic [10:0] f, input int nbits, input int glitch_at,
                           input bit pop_at_stop);
    for (int k = 0; k < nbits; k++) begin
      ps2_data = f[k];
      repeat (6) @(negedge clk);
      if (k == glitch_at) begin
        ps2_clk = 1'b0;
        repeat (FILT_LEN - 1) @(negedge clk);
        ps2_clk = 1'b1;
      end
      repeat (6) @(negedge clk);
      ps2_clk = 1'b0;
      if (pop_at_stop && k == 10) begin
        repeat (6) @(negedge clk);
        popped = {ev_if.ev_ext, ev_if.ev_break, ev_if.ev_code};
        ev_if.ev_ready = 1'b1;
        @(negedge clk);
        ev_if.ev_ready = 1'b0;
        repeat (3) @(negedge clk);
      end else begin
        repeat (10) @(negedge clk);
      end
      ps2_clk = 1'b1;
    end
    ps2_data = 1'b1;
    repeat (12) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b);
    send_bits(mk(b, 1'b0, 1'b0), 11, -1, 1'b0);
    model_byte(b);
  endtask

  task automatic drain_all(input string tag);
    logic [9:0] exp;
    while (q.size() > 0) begin
      exp = q.pop_front();
      n_checks++;
      if (ev_if.ev_valid !== 1'b1 || {ev_if.ev_ext, ev_if.ev_break, ev_if.ev_code} !== exp) begin
        n_fail++;
        $display("FAIL %s event: got valid=%b {ext,brk,code}=%h want valid=1 %h", tag,
                 ev_if.ev_valid, {ev_if.ev_ext, ev_if.ev_break, ev_if.ev_code}, exp);
      end
      ev_if.ev_ready = 1'b1;
      @(negedge clk);
      ev_if.ev_ready = 1'b0;
    end
    n_checks++;
    if ({ev_if.ev_valid, ev_if.ev_ext, ev_if.ev_break, ev_if.ev_code} !== 11'd0) begin
      n_fail++;
      $display("FAIL %s empty: got valid=%b head=%h want all 0", tag, ev_if.ev_valid,
               {ev_if.ev_ext, ev_if.ev_break, ev_if.ev_code});
    end
  endtask

  task automatic check_held(input string tag);
    n_checks++;
    if (key_held !== m_held || dir !== mdir(m_held)) begin
      n_fail++;
      $display("FAIL %s held/dir: got %b/%0d want %b/%0d", tag, key_held, dir, m_held, mdir(m_held));
    end
  endtask

  task automatic test_reset();
    n_checks++;
    if ({ev_if.ev_valid, ev_if.ev_code, ev_if.ev_break, ev_if.ev_ext, key_held, dir, frame_err, ovf} !== '0) begin
      n_fail++;
      $display("FAIL reset outputs: got %b want 0", {ev_if.ev_valid, ev_if.ev_code, ev_if.ev_break,
               ev_if.ev_ext, key_held, dir, frame_err, ovf});
    end
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    n_checks++;
    if ({ev_if.ev_valid, key_held, dir, frame_err, ovf} !== '0 || err_cnt != 0) begin
      n_fail++;
      $display("FAIL post-reset idle: got valid=%b held=%b err_cnt=%0d want 0", ev_if.ev_valid, key_held, err_cnt);
    end
  endtask

  task automatic test_make();
    send_byte(8'h1D);
    n_checks++;
    if (ev_if.ev_valid !== 1'b1 || ev_if.ev_code !== 8'h1D || ev_if.ev_break !== 1'b0) begin
      n_fail++;
      $display("FAIL make_w head: got v=%b code=%h brk=%b want 1 1d 0", ev_if.ev_valid, ev_if.ev_code, ev_if.ev_break);
    end
    n_checks++;
    if (key_held !== 4'b0001 || dir !== 2'd1) begin
      n_fail++;
      $display("FAIL make_w held: got %b dir %0d want 0001 dir 1", key_held, dir);
    end
    n_checks++;
    if (t_dir != t_held + 1) begin
      n_fail++;
      $display("FAIL dir latency: got %0d cycles want 1", t_dir - t_held);
    end
    drain_all("make_w");
  endtask

  task automatic test_break();
    send_byte(8'hF0);
    n_checks++;
    if (ev_if.ev_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL f0 no event: got valid=%b want 0", ev_if.ev_valid);
    end
    send_byte(8'h1D);
    n_checks++;
    if (key_held !== 4'b0000 || dir !== 2'd0) begin
      n_fail++;
      $display("FAIL break_w held: got %b dir %0d want 0000 dir 0", key_held, dir);
    end
    drain_all("break_w");
  endtask

  task automatic test_dir_priority();
    logic [7:0] seq [6] = '{8'h1C, 8'h23, 8'hF0, 8'h1C, 8'h1D, 8'hF0};
    logic [1:0] want [6] = '{2'd2, 2'd2, 2'd2, 2'd3, 2'd1, 2'd1};
    for (int i = 0; i < 6; i++) begin
      send_byte(seq[i]);
      n_checks++;
      if (dir !== want[i]) begin
        n_fail++;
        $display("FAIL dir step %0d: got %0d want %0d", i, dir, want[i]);
      end
    end
    send_byte(8'h23);
    send_byte(8'hF0);
    send_byte(8'h1D);
    check_held("dir_release");
    drain_all("dir_prio");
  endtask

  task automatic test_kbd_error();
    send_byte(8'hF0);
    send_byte(8'h00);
    send_byte(8'h1D);
    check_held("kerr");
    send_byte(8'hF0);
    send_byte(8'hFF);
    n_checks++;
    if (ev_if.ev_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL kerr queue: got valid=%b want 1", ev_if.ev_valid);
    end
    send_byte(8'hF0);
    send_byte(8'h1D);
    check_held("kerr_rel");
    drain_all("kerr");
  endtask

  task automatic test_frame_errors();
    int e0;
    e0 = err_cnt;
    send_bits(mk(8'h1D, 1'b1, 1'b0), 11, -1, 1'b0);
    n_checks++;
    if (err_cnt != e0 + 1 || ev_if.ev_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL parity err: got pulses=%0d valid=%b want 1 0", err_cnt - e0, ev_if.ev_valid);
    end
    check_held("parity");
    e0 = err_cnt;
    send_bits(mk(8'h1D, 1'b0, 1'b1), 11, -1, 1'b0);
    n_checks++;
    if (err_cnt != e0 + 1 || ev_if.ev_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL stop err: got pulses=%0d valid=%b want 1 0", err_cnt - e0, ev_if.ev_valid);
    end
    check_held("stop");
  endtask

  task automatic test_timeout();
    int e0;
    e0 = err_cnt;
    send_bits(mk(8'h1C, 1'b0, 1'b0), 4, -1, 1'b0);
    repeat (TIMEOUT_CYC + 20) @(negedge clk);
    n_checks++;
    if (err_cnt != e0 + 1) begin
      n_fail++;
      $display("FAIL timeout pulse: got %0d pulses want 1", err_cnt - e0);
    end
    send_byte(8'h1C);
    n_checks++;
    if (key_held !== 4'b0010 || err_cnt != e0 + 1) begin
      n_fail++;
      $display("FAIL after timeout: got held=%b pulses=%0d want 0010 1", key_held, err_cnt - e0);
    end
    send_byte(8'hF0);
    send_byte(8'h1C);
    drain_all("timeout");
  endtask

  task automatic test_glitch();
    int e0;
    e0 = err_cnt;
    send_bits(mk(8'h1B, 1'b0, 1'b0), 11, 5, 1'b0);
    model_byte(8'h1B);
    n_checks++;
    if (err_cnt != e0 || key_held !== 4'b1000 || dir !== 2'd0) begin
      n_fail++;
      $display("FAIL glitch: got pulses=%0d held=%b dir=%0d want 0 1000 0", err_cnt - e0, key_held, dir);
    end
    send_byte(8'hF0);
    send_byte(8'h1B);
    drain_all("glitch");
  endtask

  task automatic test_overflow();
    logic [7:0] fill [8] = '{8'h15, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D};
    for (int i = 0; i < 8; i++) send_byte(fill[i]);
    n_checks++;
    if (ovf !== 1'b0) begin
      n_fail++;
      $display("FAIL ovf early: got %b want 0", ovf);
    end
    send_byte(8'h1D);
    n_checks++;
    if (ovf !== 1'b1 || key_held !== 4'b0001) begin
      n_fail++;
      $display("FAIL ovf drop: got ovf=%b held=%b want 1 0001", ovf, key_held);
    end
    ovf_clr = 1'b1;
    @(negedge clk);
    ovf_clr = 1'b0;
    n_checks++;
    if (ovf !== 1'b0) begin
      n_fail++;
      $display("FAIL ovf_clr: got %b want 0", ovf);
    end
    drain_all("overflow");
    send_byte(8'hF0);
    send_byte(8'h1D);
    check_held("ovf_rel");
    drain_all("ovf_rel");
  endtask

  task automatic test_back_to_back();
    logic [7:0] fill [8] = '{8'h15, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D};
    logic [9:0] exp;
    for (int i = 0; i < 8; i++) send_byte(fill[i]);
    send_bits(mk(8'h2C, 1'b0, 1'b0), 11, -1, 1'b1);
    exp = q.pop_front();
    n_checks++;
    if (popped !== exp) begin
      n_fail++;
      $display("FAIL b2b popped: got %h want %h", popped, exp);
    end
    model_byte(8'h2C);
    n_checks++;
    if (ovf !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b drop: got ovf=%b want 0", ovf);
    end
    drain_all("b2b");
  endtask

  task automatic test_ext();
    send_byte(8'hE0);
    send_byte(8'h6B);
`ifdef PS2_EXT_EN
    n_checks++;
    if (ev_if.ev_ext !== 1'b1 || ev_if.ev_code !== 8'h6B || key_held !== 4'b0010) begin
      n_fail++;
      $display("FAIL ext make: got ext=%b code=%h held=%b want 1 6b 0010", ev_if.ev_ext, ev_if.ev_code, key_held);
    end
    send_byte(8'hE0);
    send_byte(8'hF0);
    send_byte(8'h6B);
`else
    n_checks++;
    if (ev_if.ev_ext !== 1'b0 || ev_if.ev_code !== 8'h6B || key_held !== 4'b0000) begin
      n_fail++;
      $display("FAIL ext alias: got ext=%b code=%h held=%b want 0 6b 0000", ev_if.ev_ext, ev_if.ev_code, key_held);
    end
`endif
    check_held("ext");
    drain_all("ext");
  endtask

  task automatic test_midframe_reset();
    send_byte(8'h1D);
    send_bits(mk(8'h1C, 1'b0, 1'b0), 5, -1, 1'b0);
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({ev_if.ev_valid, ev_if.ev_code, ev_if.ev_break, ev_if.ev_ext, key_held, dir, frame_err, ovf} !== '0) begin
      n_fail++;
      $display("FAIL async reset: got %b want 0", {ev_if.ev_valid, ev_if.ev_code, ev_if.ev_break,
               ev_if.ev_ext, key_held, dir, frame_err, ovf});
    end
    q.delete();
    m_brk  = 1'b0;
    m_ext  = 1'b0;
    m_held = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    send_byte(8'h1C);
    check_held("post_rst");
    drain_all("post_rst");
  endtask

  initial begin
    rst_n          = 1'b0;
    ps2_clk        = 1'b1;
    ps2_data       = 1'b1;
    ovf_clr        = 1'b0;
    ev_if.ev_ready = 1'b0;
    m_brk          = 1'b0;
    m_ext          = 1'b0;
    m_held         = '0;
    repeat (3) @(negedge clk);
    test_reset();
    test_make();
    test_break();
    test_dir_priority();
    test_kbd_error();
    test_frame_errors();
    test_timeout();
    test_glitch();
    test_overflow();
    test_back_to_back();
    test_ext();
    test_midframe_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
